bmem_responder: RTL and testbench

Cycle-level responder for the 64-bit burst memory port the pipelined core drives through its cache unit. It accepts line-granular read and write bursts, stores lines in an internal array, and returns read data as 4 x 64-bit beats after a programmable latency. It serves as the memory-side endpoint of the bmem interface in simulation tops and FPGA bring-up builds.

---
 rtl/bmem_responder.sv | 189 ++++++++++++++++++
 tb/tb_bmem_responder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_responder.sv
// Memory-side endpoint of the 64-bit bmem burst port: line array, in-order read queue with
// programmable return latency, 4-beat write bursts. Define BMEM_RAND_STALL_EN for LFSR ready stalls.
module bmem_responder #(
    parameter int MEM_LINES  = 1024,
    parameter int QDEPTH     = 4,
    parameter int RD_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic        bmem_err
);
    localparam int IW = $clog2(MEM_LINES);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic {IDLE = 1'b0, WR_BURST = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    wbeat_q, wbeat_d;
    logic [IW-1:0] wline_q, wline_d;
    logic          alive_q;
    logic          err_q, err_d;
    logic [15:0]   now_q, now_d;
    logic [26:0]   q_addr_q  [QDEPTH];
    logic [15:0]   q_stamp_q [QDEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          str_active_q, str_active_d;
    logic [1:0]    str_beat_q, str_beat_d;
    logic [IW-1:0] str_line_q, str_line_d;
    logic [31:0]   raddr_q, raddr_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [63:0]   mem_q [MEM_LINES*4];

    logic          stall, wr_start, wr_cont, rd_push, pop, mem_we;
    logic [IW+1:0] mem_widx;
    logic [IW-1:0] head_line;
    logic [15:0]   age;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^bmem_addr[4:0];
    assign head_line        = q_addr_q[head_q][IW-1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef BMEM_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        stall  = (lfsr_q[1:0] == 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    // Write bursts only start with no read queued or streaming, so reads see every earlier write.
    always_comb begin
        bmem_ready = 1'b0;
        case (state_q)
            IDLE: if (alive_q && !stall)
                      bmem_ready = bmem_write ? (count_q == '0 && !str_active_q)
                                              : (count_q < CW'(QDEPTH));
            WR_BURST: bmem_ready = 1'b1;
            default: bmem_ready = 1'b0;
        endcase
    end

    always_comb begin
        wr_start = (state_q == IDLE) && bmem_write && bmem_ready;
        rd_push  = (state_q == IDLE) && bmem_read && !bmem_write && bmem_ready;
        wr_cont  = (state_q == WR_BURST) && bmem_write && !bmem_read;
        mem_we   = wr_start || wr_cont;
        mem_widx = wr_start ? {bmem_addr[5 +: IW], 2'b00} : {wline_q, wbeat_q};
        age      = now_q - q_stamp_q[head_q];
        pop      = (count_q != '0) && (!str_active_q || str_beat_q == 2'd3)
                   && (age >= 16'(RD_LATENCY));
        err_d    = err_q || (bmem_read && bmem_write) || ((state_q == WR_BURST) && !wr_cont);
        now_d    = now_q + 16'd1;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        wbeat_d = wbeat_q;
        wline_d = wline_q;
        case (state_q)
            IDLE: if (wr_start) begin
                state_d = WR_BURST;
                wbeat_d = 2'd1;
                wline_d = bmem_addr[5 +: IW];
            end
            WR_BURST: begin
                if (!wr_cont || wbeat_q == 2'd3) state_d = IDLE;
                else                             wbeat_d = wbeat_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d  = pop ? ptr_inc(head_q) : head_q;
        tail_d  = rd_push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q + CW'(rd_push) - CW'(pop);
    end

    // The streamer pops while showing beat 3, so consecutive bursts run without a bubble.
    always_comb begin
        str_active_d = 1'b0;
        str_beat_d   = str_beat_q;
        str_line_d   = str_line_q;
        raddr_d      = raddr_q;
        rdata_d      = rdata_q;
        if (pop) begin
            str_active_d = 1'b1;
            str_beat_d   = 2'd0;
            str_line_d   = head_line;
            raddr_d      = {q_addr_q[head_q], 5'b0};
            rdata_d      = mem_q[{head_line, 2'b00}];
        end else if (str_active_q && str_beat_q != 2'd3) begin
            str_active_d = 1'b1;
            str_beat_d   = str_beat_q + 2'd1;
            rdata_d      = mem_q[{str_line_q, str_beat_q + 2'd1}];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wbeat_q      <= '0;
            wline_q      <= '0;
            alive_q      <= 1'b0;
            err_q        <= 1'b0;
            now_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            str_active_q <= 1'b0;
            str_beat_q   <= '0;
            str_line_q   <= '0;
            raddr_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            wbeat_q      <= wbeat_d;
            wline_q      <= wline_d;
            alive_q      <= 1'b1;
            err_q        <= err_d;
            now_q        <= now_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            str_active_q <= str_active_d;
            str_beat_q   <= str_beat_d;
            str_line_q   <= str_line_d;
            raddr_q      <= raddr_d;
            rdata_q      <= rdata_d;
        end
    end

    // NOTE: storage arrays carry no reset; queue slots are qualified by count_q.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_widx] <= bmem_wdata;
        if (rd_push) begin
            q_addr_q[tail_q]  <= bmem_addr[31:5];
            q_stamp_q[tail_q] <= now_q;
        end
    end

    assign bmem_raddr  = raddr_q;
    assign bmem_rdata  = rdata_q;
    assign bmem_rvalid = str_active_q;
    assign bmem_err    = err_q;
endmodule

// File: tb/tb_bmem_responder.sv
// Self-checking bench for bmem_responder: per-cycle reference model (line store, scheduled
// beat list, ready rules) plus directed scenarios and a randomized read/write mix.
module tb_bmem_responder;
    localparam int MEM_LINES  = 1024;
    localparam int QDEPTH     = 4;
    localparam int RD_LATENCY = 8;
    localparam int IW         = $clog2(MEM_LINES);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bmem_addr = '0;
    logic        bmem_read = 1'b0;
    logic        bmem_write = 1'b0;
    logic [63:0] bmem_wdata = '0;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        bmem_err;

    always #5 clk = ~clk;

    bmem_responder #(.MEM_LINES(MEM_LINES), .QDEPTH(QDEPTH), .RD_LATENCY(RD_LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
        .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
        .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
        .bmem_err(bmem_err)
    );

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic [31:0] addr;
        bit          known;
    } beat_t;

    beat_t       exp_q[$];
    int          starts_q[$];
    logic [63:0] mem_m [int];
    int          cyc, last_start, checks, errors;
    int          rv_first, rv_last, beats_seen;
    bit          err_m, in_wr;
    int          wr_beat, wr_line;

    task automatic reset_model();
        exp_q.delete();
        starts_q.delete();
        cyc = 0;
        last_start = -100;
        err_m = 1'b0;
        in_wr = 1'b0;
    endtask

    task automatic idle_inputs();
        bmem_read = 1'b0;
        bmem_write = 1'b0;
        bmem_addr = '0;
        bmem_wdata = '0;
    endtask

    // One clock cycle: compare outputs against the model at negedge, then advance the model.
    task automatic step(output bit acc);
        bit    exp_rdy;
        int    n_q, s, idx;
        beat_t b;
        @(negedge clk);
        n_q = 0;
        foreach (starts_q[i]) if (starts_q[i] > cyc) n_q++;
        if (in_wr)           exp_rdy = 1'b1;
        else if (bmem_write) exp_rdy = (cyc > last_start + 3);
        else                 exp_rdy = (n_q < QDEPTH);
        checks++;
`ifdef BMEM_RAND_STALL_EN
        if ((bmem_ready === 1'b1 && !exp_rdy) || (in_wr && bmem_ready !== 1'b1)) begin
`else
        if (bmem_ready !== exp_rdy) begin
`endif
            errors++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, bmem_ready, exp_rdy);
        end
        checks++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            b = exp_q.pop_front();
            if (bmem_rvalid !== 1'b1 || bmem_raddr !== b.addr || (b.known && bmem_rdata !== b.data)) begin
                errors++;
                $display("FAIL beat cyc=%0d got v=%b a=%h d=%h exp a=%h d=%h",
                         cyc, bmem_rvalid, bmem_raddr, bmem_rdata, b.addr, b.data);
            end
        end else if (bmem_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid cyc=%0d got=%b exp=0", cyc, bmem_rvalid);
        end
        checks++;
        if (bmem_err !== err_m) begin
            errors++;
            $display("FAIL err cyc=%0d got=%b exp=%b", cyc, bmem_err, err_m);
        end
        if (bmem_rvalid === 1'b1) begin
            beats_seen++;
            if (rv_first < 0) rv_first = cyc;
            rv_last = cyc;
        end
        acc = 1'b0;
        if (in_wr) begin
            if (bmem_write && !bmem_read) begin
                mem_m[wr_line * 4 + wr_beat] = bmem_wdata;
                wr_beat++;
                if (wr_beat == 4) in_wr = 1'b0;
                acc = 1'b1;
            end else begin
                err_m = 1'b1;
                in_wr = 1'b0;
            end
        end else begin
            if (bmem_read && bmem_write) err_m = 1'b1;
            if (bmem_ready === 1'b1 && bmem_write) begin
                wr_line = int'(bmem_addr[5 +: IW]);
                mem_m[wr_line * 4] = bmem_wdata;
                wr_beat = 1;
                in_wr = 1'b1;
                acc = 1'b1;
            end else if (bmem_ready === 1'b1 && bmem_read) begin
                s = cyc + 1 + RD_LATENCY;
                if (s < last_start + 4) s = last_start + 4;
                last_start = s;
                starts_q.push_back(s);
                idx = int'(bmem_addr[5 +: IW]);
                for (int k = 0; k < 4; k++) begin
                    b.cyc   = s + k;
                    b.addr  = {bmem_addr[31:5], 5'b0};
                    b.known = mem_m.exists(idx * 4 + k);
                    b.data  = b.known ? mem_m[idx * 4 + k] : '0;
                    exp_q.push_back(b);
                end
                acc = 1'b1;
            end
        end
        while (starts_q.size() > 0 && starts_q[0] < cyc - 8) void'(starts_q.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [63:0] d,
                       output int waited);
        bit acc;
        waited = 0;
        bmem_read = rd;
        bmem_write = wr;
        bmem_addr = a;
        bmem_wdata = d;
        step(acc);
        while (!acc && waited < 200) begin
            waited++;
            step(acc);
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL req_timeout got=not_accepted exp=accepted rd=%b wr=%b", rd, wr);
        end
        idle_inputs();
    endtask

    task automatic write_line(input logic [31:0] a, input logic [255:0] line, output int waited);
        bit acc;
        req(1'b0, 1'b1, a, line[63:0], waited);
        for (int k = 1; k < 4; k++) begin
            bmem_write = 1'b1;
            bmem_wdata = line[64 * k +: 64];
            bmem_addr  = $urandom;
            step(acc);
        end
        idle_inputs();
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            step(acc);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        step(acc);
    endtask

    function automatic logic [31:0] mk_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[5 +: IW] = IW'(idx);
        return a;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bmem_ready !== 1'b0 || bmem_rvalid !== 1'b0 || bmem_rdata !== 64'd0 ||
            bmem_raddr !== 32'd0 || bmem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals got rdy=%b v=%b d=%h a=%h e=%b exp all 0",
                     bmem_ready, bmem_rvalid, bmem_rdata, bmem_raddr, bmem_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bmem_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got=%b exp=0", bmem_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bmem_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge got=%b exp=1", bmem_ready);
        end
        reset_model();
    endtask

    task automatic test_write_read();
        int waited, ca;
        write_line(32'h0000_1000, {64'd4, 64'd3, 64'd2, 64'd1}, waited);
        rv_first = -1;
        beats_seen = 0;
        req(1'b1, 1'b0, 32'h0000_1000, '0, waited);
        ca = cyc - 1;
        drain();
        checks++;
        if (rv_first != ca + 1 + RD_LATENCY || rv_last != rv_first + 3 || beats_seen != 4) begin
            errors++;
            $display("FAIL wr_rd_timing got first=%0d last=%0d n=%0d exp first=%0d n=4",
                     rv_first, rv_last, beats_seen, ca + 1 + RD_LATENCY);
        end
    endtask

    task automatic test_queue_full();
        int waited;
        rv_first = -1;
        beats_seen = 0;
        for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 32'h0000_1000 | (i << 20), '0, waited);
        req(1'b1, 1'b0, 32'h0050_1000, '0, waited);
        checks++;
        if (waited != RD_LATENCY - 3) begin
            errors++;
            $display("FAIL qfull_wait got=%0d exp=%0d", waited, RD_LATENCY - 3);
        end
        drain();
        checks++;
        if (beats_seen != 20 || rv_last - rv_first != 19) begin
            errors++;
            $display("FAIL qfull_beats got n=%0d span=%0d exp n=20 span=19", beats_seen, rv_last - rv_first);
        end
    endtask

    task automatic test_write_blocked();
        int waited;
        req(1'b1, 1'b0, 32'h0000_1000, '0, waited);
        write_line(32'h0000_1000, {64'hD4, 64'hC3, 64'hB2, 64'hA1}, waited);
        checks++;
        if (waited != RD_LATENCY + 4) begin
            errors++;
            $display("FAIL wr_block_wait got=%0d exp=%0d", waited, RD_LATENCY + 4);
        end
        req(1'b1, 1'b0, 32'h0000_1000, '0, waited);
        drain();
    endtask

    task automatic test_random();
        int lines[8];
        int waited, idx;
        bit acc;
        for (int i = 0; i < 8; i++) begin
            lines[i] = 16 + i * 37 + $urandom_range(0, 30);
            write_line(mk_addr(lines[i]), {$urandom, $urandom, $urandom, $urandom, $urandom,
                                           $urandom, $urandom, $urandom}, waited);
        end
        repeat (300) begin
            idx = lines[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) < 4)
                write_line(mk_addr(idx), {$urandom, $urandom, $urandom, $urandom, $urandom,
                                          $urandom, $urandom, $urandom}, waited);
            else
                req(1'b1, 1'b0, mk_addr(idx), '0, waited);
            repeat ($urandom_range(0, 2)) step(acc);
        end
        drain();
    endtask

    task automatic test_err();
        int  waited;
        bit  acc;
        beats_seen = 0;
        req(1'b1, 1'b1, 32'h0000_2000, 64'h1111, waited);
        for (int k = 1; k < 4; k++) begin
            bmem_write = 1'b1;
            bmem_wdata = 64'h1111 + 64'(k);
            step(acc);
        end
        idle_inputs();
        repeat (20) step(acc);
        checks++;
        if (bmem_err !== 1'b1 || beats_seen != 0) begin
            errors++;
            $display("FAIL rw_same_cycle got err=%b beats=%0d exp err=1 beats=0", bmem_err, beats_seen);
        end
        req(1'b1, 1'b0, 32'h0000_2000, '0, waited);
        drain();
        req(1'b0, 1'b1, 32'h0000_1000, 64'hEE00, waited);
        bmem_write = 1'b1;
        bmem_wdata = 64'hEE01;
        step(acc);
        idle_inputs();
        step(acc);
        checks++;
        if (in_wr || bmem_err !== 1'b1) begin
            errors++;
            $display("FAIL abort got err=%b exp=1", bmem_err);
        end
        req(1'b1, 1'b0, 32'h0000_1000, '0, waited);
        drain();
    endtask

    task automatic test_reset_mid_burst();
        int waited, n;
        bit acc;
        req(1'b1, 1'b0, 32'h0000_1000, '0, waited);
        n = 0;
        while (cyc < last_start + 2 && n < 100) begin
            step(acc);
            n++;
        end
        checks++;
        if (bmem_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_beat2 got rvalid=%b exp=1", bmem_rvalid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bmem_rvalid !== 1'b0 || bmem_ready !== 1'b0 || bmem_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b rdy=%b e=%b exp 0 0 0", bmem_rvalid, bmem_ready, bmem_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        reset_model();
        beats_seen = 0;
        repeat (20) step(acc);
        checks++;
        if (beats_seen != 0) begin
            errors++;
            $display("FAIL stale_beats got=%0d exp=0", beats_seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rv_first = -1;
        rv_last = -1;
        beats_seen = 0;
        reset_model();
        test_reset();
        test_write_read();
        test_queue_full();
        test_write_blocked();
        test_random();
        test_err();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
